// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N output-stationary systolic MAC array: clears the grid,
// streams K skewed operand steps into its edges, then offers the N result rows.
module systolic_ctrl #(
   parameter int N  = 4,
   parameter int KW = 8,
   parameter int RW = $clog2(N)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [KW-1:0]   k_len,
   output logic            busy,
   output logic            done,
   output logic            load_weights,
   output logic            compute_en,
   output logic [N*KW-1:0] a_idx,
   output logic [N-1:0]    a_valid,
   output logic [N*KW-1:0] b_idx,
   output logic [N-1:0]    b_valid,
   output logic            rd_valid,
   input  logic            rd_ready,
   output logic [RW-1:0]   rd_row
);

   // Step counter is wide enough to reach kreg + 2N - 3 without wrapping.
   localparam int TW = KW + RW + 1;

   typedef enum logic [2:0] {IDLE, CLEAR, FEED, READ, DONE} state_t;

   state_t            state;
   logic [KW-1:0]     kreg;
   logic [TW-1:0]     t;
   logic [TW-1:0]     step_next;
   logic [TW-1:0]     last_step;
   logic [N-1:0]      sk_valid;
   logic [N*KW-1:0]   sk_idx;

   // Skew pattern for the step about to be presented; rows and columns share it.
   always_comb begin
      step_next = (state == FEED) ? t + 1'b1 : '0;
      last_step = TW'(kreg) + TW'(2 * N - 3);
      sk_valid  = '0;
      sk_idx    = '0;
      for (int i = 0; i < N; i++) begin
         if ((step_next >= TW'(i)) && ((step_next - TW'(i)) < TW'(kreg))) begin
            sk_valid[i]          = 1'b1;
            sk_idx[i*KW +: KW]   = KW'(step_next - TW'(i));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         kreg         <= '0;
         t            <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         load_weights <= 1'b0;
         compute_en   <= 1'b0;
         a_idx        <= '0;
         a_valid      <= '0;
         b_idx        <= '0;
         b_valid      <= '0;
         rd_valid     <= 1'b0;
         rd_row       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  kreg         <= k_len;
                  state        <= CLEAR;
                  busy         <= 1'b1;
                  load_weights <= 1'b1;
               end
            end
            CLEAR: begin
               load_weights <= 1'b0;
               if (kreg != '0) begin
                  state      <= FEED;
                  t          <= '0;
                  compute_en <= 1'b1;
                  a_valid    <= sk_valid;
                  a_idx      <= sk_idx;
                  b_valid    <= sk_valid;
                  b_idx      <= sk_idx;
               end else begin
                  state    <= READ;
                  rd_valid <= 1'b1;
                  rd_row   <= '0;
               end
            end
            FEED: begin
               if (t == last_step) begin
                  state      <= READ;
                  compute_en <= 1'b0;
                  a_valid    <= '0;
                  a_idx      <= '0;
                  b_valid    <= '0;
                  b_idx      <= '0;
                  rd_valid   <= 1'b1;
                  rd_row     <= '0;
               end else begin
                  t       <= step_next;
                  a_valid <= sk_valid;
                  a_idx   <= sk_idx;
                  b_valid <= sk_valid;
                  b_idx   <= sk_idx;
               end
            end
            READ: begin
               // rd_valid is always high here, so rd_ready alone completes the handshake.
               if (rd_ready) begin
                  if (rd_row == RW'(N - 1)) begin
                     state    <= DONE;
                     rd_valid <= 1'b0;
                     rd_row   <= '0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                  end else begin
                     rd_row <= rd_row + 1'b1;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Randomized bench for systolic_ctrl: a timeline model (cycles since start, rows
// accepted) predicts every output each cycle.
module tb_systolic_ctrl;

   localparam int N  = 4;
   localparam int KW = 8;
   localparam int RW = $clog2(N);

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [KW-1:0]   k_len;
   logic            busy;
   logic            done;
   logic            load_weights;
   logic            compute_en;
   logic [N*KW-1:0] a_idx;
   logic [N-1:0]    a_valid;
   logic [N*KW-1:0] b_idx;
   logic [N-1:0]    b_valid;
   logic            rd_valid;
   logic            rd_ready;
   logic [RW-1:0]   rd_row;

   systolic_ctrl #(.N(N), .KW(KW), .RW(RW)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .k_len        (k_len),
      .busy         (busy),
      .done         (done),
      .load_weights (load_weights),
      .compute_en   (compute_en),
      .a_idx        (a_idx),
      .a_valid      (a_valid),
      .b_idx        (b_idx),
      .b_valid      (b_valid),
      .rd_valid     (rd_valid),
      .rd_ready     (rd_ready),
      .rd_row       (rd_row)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference: active run, cycles elapsed since acceptance, latched K, rows taken.
   bit m_active = 1'b0;
   int m_cyc    = 0;
   int m_k      = 0;
   int m_rows   = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   function automatic int feed_len(input int k);
      return (k == 0) ? 0 : k + 2 * N - 2;
   endfunction

   // 0 idle, 1 clear, 2 feed, 3 read, 4 done
   function automatic int cur_phase();
      if (!m_active) return 0;
      if (m_cyc == 1) return 1;
      if (m_cyc - 2 < feed_len(m_k)) return 2;
      if (m_rows < N) return 3;
      return 4;
   endfunction

   task automatic check_outputs();
      int              ph;
      int              tt;
      logic [N-1:0]    e_v;
      logic [N*KW-1:0] e_i;
      ph  = cur_phase();
      e_v = '0;
      e_i = '0;
      if (ph == 2) begin
         tt = m_cyc - 2;
         for (int i = 0; i < N; i++) begin
            if (tt >= i && tt - i < m_k) begin
               e_v[i]          = 1'b1;
               e_i[i*KW +: KW] = KW'(tt - i);
            end
         end
      end
      check_val("busy",         busy,         (ph >= 1 && ph <= 3));
      check_val("done",         done,         (ph == 4));
      check_val("load_weights", load_weights, (ph == 1));
      check_val("compute_en",   compute_en,   (ph == 2));
      check_val("rd_valid",     rd_valid,     (ph == 3));
      check_val("rd_row",       rd_row,       (ph == 3) ? m_rows : 0);
      check_val("a_valid",      a_valid,      e_v);
      check_val("a_idx",        a_idx,        e_i);
      check_val("b_valid",      b_valid,      e_v);
      check_val("b_idx",        b_idx,        e_i);
   endtask

   task automatic model_update(input bit s, input int k, input bit rdy, input bit rst);
      int ph;
      ph = cur_phase();
      if (rst) begin
         m_active = 1'b0;
      end else if (ph == 0) begin
         if (s) begin
            m_active = 1'b1;
            m_cyc    = 1;
            m_k      = k;
            m_rows   = 0;
         end
      end else if (ph == 4) begin
         m_active = 1'b0;
      end else begin
         if (ph == 3 && rdy) m_rows++;
         m_cyc++;
      end
   endtask

   // Drive one cycle of inputs (from the falling edge), clock it, check outputs.
   task automatic step(input bit s, input int k, input bit rdy, input bit rst);
      start    = s;
      k_len    = KW'(k);
      rd_ready = rdy;
      reset    = rst;
      model_update(s, k & ((1 << KW) - 1), rdy, rst);
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   // rmode: 0 always ready, 1 ready pattern 1,0,0, 2 random ready.
   task automatic run_job(input int k, input int rmode, input bit hold_start);
      int n;
      bit rdy;
      n = 0;
      step(1'b1, k, 1'b1, 1'b0);
      while (m_active && n < 2000) begin
         case (rmode)
            0:       rdy = 1'b1;
            1:       rdy = (n % 3 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         step(hold_start, $urandom_range(0, 255), rdy, 1'b0);
         n++;
      end
      check_val("run_bound", m_active, 1'b0);
   endtask

   initial begin
      int n;
      step(1'b0, 0, 1'b0, 1'b1);
      step(1'b0, 0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, $urandom_range(0, 255), 1'b0, 1'b0);

      run_job(3, 0, 1'b0);
      step(1'b0, 0, 1'b1, 1'b0);
      run_job(0, 0, 1'b0);
      run_job(6, 1, 1'b0);
      run_job(4, 2, 1'b1);
      run_job(7, 2, 1'b1);
      step(1'b0, 0, 1'b1, 1'b0);

      // Abort in the middle of FEED, then a clean run with K=2.
      step(1'b1, 5, 1'b1, 1'b0);
      n = 0;
      while (!(cur_phase() == 2 && m_cyc - 2 == 4) && n < 50) begin
         step(1'b0, $urandom_range(0, 255), 1'b1, 1'b0);
         n++;
      end
      check_val("reach_t4", m_cyc - 2, 4);
      step(1'b0, 0, 1'b1, 1'b1);
      step(1'b0, 0, 1'b1, 1'b0);
      step(1'b0, 0, 1'b1, 1'b0);
      run_job(2, 0, 1'b0);

      for (int r = 0; r < 8; r++) begin
         run_job($urandom_range(0, 12), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
         for (int g = 0; g < int'($urandom_range(0, 2)); g++)
            step(1'b0, $urandom_range(0, 255), 1'($urandom_range(0, 1)), 1'b0);
      end
      run_job(255, 2, 1'b0);
      step(1'b0, 0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
